xor_bist_ctrl: RTL and testbench
================================

Name: xor_bist_ctrl

Overview:
Built-in self-test sequencer for the lab's 2-input XOR cell. On a start pulse it drives the cell through all four input vectors (00, 01, 10, 11), optionally over several passes. It waits a programmable settle time, compares the cell output against the expected a^b, and reports pass/fail, error count and first failing vector. It sits beside the XOR instance and owns its a/b inputs while busy.

Parameters:
SETTLE_CYC, 1, cycles between driving a vector and sampling dut_out; legal range >=1
REPEAT, 1, number of full 4-vector passes per run; legal range >=1
ERR_W, 4, width of err_cnt; counter saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  terminate a run; returns to IDLE
dut_out  input  1  output of the XOR cell under test
dut_a  output  1  XOR cell input a (registered)
dut_b  output  1  XOR cell input b (registered)
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at normal run completion
pass  output  1  result of last completed run; valid from done, held until next start
err_cnt  output  ERR_W  mismatches in current/last run, saturating
fail_valid  output  1  at least one mismatch captured this run
fail_vec  output  2  {a,b} of first mismatch; valid when fail_valid

Behaviour:
- One clock: clk. Reset: rst_n, asynchronous, active-low. All outputs reset to 0; FSM to IDLE.
- All outputs are registered.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE. Internal counters: 2-bit vec, settle counter, pass counter.
- IDLE, start=1, abort=0: next state DRIVE. Clear vec, pass counter, err_cnt, fail_valid, fail_vec and pass. Set busy.
- DRIVE (1 cycle): dut_a=vec[1], dut_b=vec[0]. Load the settle counter. Next state SETTLE.
- SETTLE: lasts exactly SETTLE_CYC cycles, then CHECK.
- CHECK (1 cycle): compare dut_out with vec[1]^vec[0].
  - On mismatch, increment err_cnt, saturating at its maximum with no wrap.
  - On the first mismatch of the run, set fail_valid=1 and fail_vec=vec; later mismatches do not overwrite.
  - If vec=3 and the pass counter is REPEAT-1, next state DONE. Otherwise vec increments, wrapping 3->0 and bumping the pass counter, and the next state is DRIVE.
- dut_a/dut_b hold the vector through DRIVE, SETTLE and CHECK. They are 0 in IDLE and DONE.
- DONE (1 cycle): done=1, pass=(err_cnt==0), busy=0. Next state IDLE.
- Latency: start sampled at edge k gives busy=1 from cycle k+1 and done at cycle k+1+REPEAT*4*(SETTLE_CYC+2). With defaults, done is at k+13.
- start while busy: ignored, with no restart and no counter change.
- abort in DRIVE, SETTLE or CHECK: next state IDLE. busy=0, dut_a/dut_b=0, no done pulse, pass=0. err_cnt, fail_valid and fail_vec keep their values at abort time.
- abort in IDLE or DONE: no effect. A DONE state still completes with its done pulse.
- start and abort both high in IDLE: abort wins, so the FSM stays IDLE and results are not cleared.
- abort and mismatch in the same CHECK cycle: the mismatch is still counted and captured, then the FSM goes to IDLE.
- rst_n asserted mid-run: immediate return to IDLE with all outputs 0, no done pulse.

Test Plan:
- Correct XOR cell, defaults; start pulse at edge k -> vectors 00,01,10,11 on dut_a/dut_b, done=1 at k+13 only, pass=1, err_cnt=0, fail_valid=0.
- XNOR-behaving cell (dut_out=~(a^b)) -> done at k+13, pass=0, err_cnt=4, fail_valid=1, fail_vec=2'b00.
- dut_out stuck at 0, REPEAT=2, SETTLE_CYC=3 -> done at k+1+2*4*5=k+41, err_cnt=4 (vectors 01,10 twice), fail_vec=2'b01, pass=0.
- Correct cell, abort asserted during vector 10 SETTLE -> IDLE next cycle, busy=0, dut_a=dut_b=0, no done pulse, pass=0. A subsequent start runs the full sequence to pass=1.
- start re-pulsed at cycles k+4 and k+12 during a run -> no effect, done still at k+13. start and abort together in IDLE -> stays IDLE, busy stays 0.
- ERR_W=2, REPEAT=2, XNOR cell -> err_cnt saturates at 3 (not 0). Separately, rst_n low mid-run -> all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/xor_bist_ctrl_if.sv
// Purpose : bundles the control handshake, result bus and XOR-cell pins of the BIST sequencer.
// Latency : none, wires only.
// Backpressure: none; start/abort are level-sampled by the controller each cycle.
// Ports   : start/abort/dut_out flow into the controller (master); dut_a/dut_b, busy, done,
//           pass, err_cnt, fail_valid and fail_vec flow out of it to the cell and the test host.
interface xor_bist_ctrl_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             abort;
    logic             dut_out;
    logic             dut_a;
    logic             dut_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [1:0]       fail_vec;

    modport master (
        input  start, abort, dut_out,
        output dut_a, dut_b, busy, done, pass, err_cnt, fail_valid, fail_vec
    );

    modport slave (
        output start, abort, dut_out,
        input  dut_a, dut_b, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
endinterface

// File: rtl/xor_bist_ctrl.sv
// Purpose : walks a 2-input XOR cell through 00,01,10,11 (REPEAT passes) and grades its output.
// Latency : start at edge k -> busy from k+1, done at k+1+REPEAT*4*(SETTLE_CYC+2).
// Backpressure: none; start ignored while busy, abort returns to IDLE keeping the error record.
// Ports   : clk, rst_n (async active-low); bus (master modport) carries start/abort/dut_out in
//           and the registered dut_a/dut_b, busy, done, pass, err_cnt, fail_valid, fail_vec out.
module xor_bist_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter int REPEAT     = 1,
    parameter int ERR_W      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    xor_bist_ctrl_if.master bus
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(REPEAT - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    state_t           state;
    logic [1:0]       vec;
    logic [1:0]       vec_nxt;
    logic [SW-1:0]    settle_cnt;
    logic [PW-1:0]    pass_cnt;

    logic             dut_a_q, dut_b_q, busy_q, done_q, pass_q, fail_valid_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [1:0]       fail_vec_q;
    logic             mism;

    assign mism    = bus.dut_out != (vec[1] ^ vec[0]);
    assign vec_nxt = vec + 2'd1;

    assign bus.dut_a      = dut_a_q;
    assign bus.dut_b      = dut_b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;

    // Outputs are written on the edge that enters the state they belong to, so dut_a/dut_b,
    // busy and done line up exactly with the DRIVE..CHECK and DONE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= 2'd0;
            settle_cnt   <= '0;
            pass_cnt     <= '0;
            dut_a_q      <= 1'b0;
            dut_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    // abort dominates start so a stray start cannot wipe the last result
                    if (bus.start && !bus.abort) begin
                        state        <= DRIVE;
                        vec          <= 2'd0;
                        pass_cnt     <= '0;
                        err_cnt_q    <= '0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= 2'd0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        dut_a_q      <= 1'b0;
                        dut_b_q      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        dut_a_q <= 1'b0;
                        dut_b_q <= 1'b0;
                    end else begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        dut_a_q <= 1'b0;
                        dut_b_q <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    // the sample is recorded even when abort arrives in the same cycle
                    if (mism) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_vec_q   <= vec;
                        end
                    end
                    if (bus.abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        dut_a_q <= 1'b0;
                        dut_b_q <= 1'b0;
                    end else if (vec == 2'd3 && pass_cnt == PASS_LAST) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // err_cnt_q still lacks this cycle's sample, so fold mism in
                        pass_q  <= (err_cnt_q == '0) && !mism;
                        dut_a_q <= 1'b0;
                        dut_b_q <= 1'b0;
                    end else begin
                        vec     <= vec_nxt;
                        dut_a_q <= vec_nxt[1];
                        dut_b_q <= vec_nxt[0];
                        if (vec == 2'd3) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xor_bist_ctrl.sv
// Purpose : three sequencer lanes (different SETTLE_CYC/REPEAT/ERR_W) share start/abort and a
//           fault mask on the XOR cell; an arithmetic timeline model predicts every output.
// Latency/backpressure: n/a (bench).
module tb_xor_bist_ctrl;
    localparam int NONE = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] mask;   // bit {a,b} set -> cell output inverted for that vector

    int n_cmp = 0;
    int n_bad = 0;

    int ls[3] = '{1, 3, 2};   // SETTLE_CYC per lane
    int lr[3] = '{1, 2, 2};   // REPEAT per lane
    int le[3] = '{4, 4, 2};   // ERR_W per lane

    int last_err[3], last_pass[3], last_fv[3], last_fvec[3];

    always #5 clk = ~clk;

    xor_bist_ctrl_if #(.ERR_W(4)) if0 ();
    xor_bist_ctrl_if #(.ERR_W(4)) if1 ();
    xor_bist_ctrl_if #(.ERR_W(2)) if2 ();

    xor_bist_ctrl #(.SETTLE_CYC(1), .REPEAT(1), .ERR_W(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    xor_bist_ctrl #(.SETTLE_CYC(3), .REPEAT(2), .ERR_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    xor_bist_ctrl #(.SETTLE_CYC(2), .REPEAT(2), .ERR_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = start;
    assign if1.start = start;
    assign if2.start = start;
    assign if0.abort = abort;
    assign if1.abort = abort;
    assign if2.abort = abort;
    assign if0.dut_out = (if0.dut_a ^ if0.dut_b) ^ mask[{if0.dut_a, if0.dut_b}];
    assign if1.dut_out = (if1.dut_a ^ if1.dut_b) ^ mask[{if1.dut_a, if1.dut_b}];
    assign if2.dut_out = (if2.dut_a ^ if2.dut_b) ^ mask[{if2.dut_a, if2.dut_b}];

    logic       busy_l[3], a_l[3], b_l[3], done_l[3], pass_l[3], fv_l[3];
    logic [1:0] fvec_l[3];
    logic [3:0] err_l[3];

    assign busy_l[0] = if0.busy;  assign busy_l[1] = if1.busy;  assign busy_l[2] = if2.busy;
    assign a_l[0]    = if0.dut_a; assign a_l[1]    = if1.dut_a; assign a_l[2]    = if2.dut_a;
    assign b_l[0]    = if0.dut_b; assign b_l[1]    = if1.dut_b; assign b_l[2]    = if2.dut_b;
    assign done_l[0] = if0.done;  assign done_l[1] = if1.done;  assign done_l[2] = if2.done;
    assign pass_l[0] = if0.pass;  assign pass_l[1] = if1.pass;  assign pass_l[2] = if2.pass;
    assign fv_l[0]   = if0.fail_valid; assign fv_l[1] = if1.fail_valid; assign fv_l[2] = if2.fail_valid;
    assign fvec_l[0] = if0.fail_vec;   assign fvec_l[1] = if1.fail_vec;   assign fvec_l[2] = if2.fail_vec;
    assign err_l[0]  = if0.err_cnt;
    assign err_l[1]  = if1.err_cnt;
    assign err_l[2]  = {2'b00, if2.err_cnt};

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Timeline of lane l, cycle c after the start edge: vector j (0..4R-1) occupies cycles
    // j*P+1 .. (j+1)*P with P=SETTLE_CYC+2, its sample is taken in cycle (j+1)*P and shows
    // from the next cycle; an abort sampled in cycle ca ends the run after cycle ca.
    task automatic check_cycle(input int l, input int c, input int ca, input logic [3:0] m);
        int p, t, nerr, first, sat, vec_i;
        bit busy_e, done_e, ran_out;
        p       = ls[l] + 2;
        t       = lr[l] * 4 * p;
        ran_out = (ca > t);
        busy_e  = (c <= t) && (c <= ca);
        done_e  = ran_out && (c == t + 1);
        vec_i   = busy_e ? ((c - 1) / p) % 4 : 0;
        nerr    = 0;
        first   = -1;
        for (int j = 0; j < 4 * lr[l]; j++) begin
            int cc;
            cc = (j + 1) * p;
            if (cc < c && cc <= ca && m[j % 4]) begin
                nerr++;
                if (first < 0) first = j % 4;
            end
        end
        sat = (1 << le[l]) - 1;
        last_err[l]  = (nerr > sat) ? sat : nerr;
        last_fv[l]   = (first >= 0) ? 1 : 0;
        last_fvec[l] = (first >= 0) ? first : 0;
        last_pass[l] = (ran_out && c >= t + 1 && nerr == 0) ? 1 : 0;
        chk($sformatf("L%0d c%0d busy", l, c), int'(busy_l[l]), int'(busy_e));
        chk($sformatf("L%0d c%0d dut_a", l, c), int'(a_l[l]), (vec_i >> 1) & 1);
        chk($sformatf("L%0d c%0d dut_b", l, c), int'(b_l[l]), vec_i & 1);
        chk($sformatf("L%0d c%0d done", l, c), int'(done_l[l]), int'(done_e));
        chk($sformatf("L%0d c%0d err_cnt", l, c), int'(err_l[l]), last_err[l]);
        chk($sformatf("L%0d c%0d fail_valid", l, c), int'(fv_l[l]), last_fv[l]);
        chk($sformatf("L%0d c%0d fail_vec", l, c), int'(fvec_l[l]), last_fvec[l]);
        chk($sformatf("L%0d c%0d pass", l, c), int'(pass_l[l]), last_pass[l]);
    endtask

    task automatic check_zero(input string why);
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("%s L%0d busy", why, l), int'(busy_l[l]), 0);
            chk($sformatf("%s L%0d dut_ab", why, l), int'({a_l[l], b_l[l]}), 0);
            chk($sformatf("%s L%0d done", why, l), int'(done_l[l]), 0);
            chk($sformatf("%s L%0d pass", why, l), int'(pass_l[l]), 0);
            chk($sformatf("%s L%0d err_cnt", why, l), int'(err_l[l]), 0);
            chk($sformatf("%s L%0d fail", why, l), int'({fv_l[l], fvec_l[l]}), 0);
        end
    endtask

    // ca: cycle whose closing edge samples abort; cs: stray start cycle; cr: reset cycle
    task automatic run(input logic [3:0] m, input int ca, input int cs, input int cr);
        mask = m;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            for (int l = 0; l < 3; l++) check_cycle(l, c, ca, m);
            if (c == cr) begin
                start = 1'b0;
                abort = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_zero($sformatf("rst c%0d", c));
                @(negedge clk);
                rst_n = 1'b1;
                for (int l = 0; l < 3; l++) begin
                    last_err[l] = 0; last_pass[l] = 0; last_fv[l] = 0; last_fvec[l] = 0;
                end
                return;
            end
            abort = (c == ca);
            start = (c == cs);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    // start and abort together while idle must leave every lane idle with its record intact
    task automatic both_idle();
        @(posedge clk);
        #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        repeat (2) begin
            @(negedge clk);
            for (int l = 0; l < 3; l++) begin
                chk($sformatf("sa L%0d busy", l), int'(busy_l[l]), 0);
                chk($sformatf("sa L%0d done", l), int'(done_l[l]), 0);
                chk($sformatf("sa L%0d dut_ab", l), int'({a_l[l], b_l[l]}), 0);
                chk($sformatf("sa L%0d err_cnt", l), int'(err_l[l]), last_err[l]);
                chk($sformatf("sa L%0d pass", l), int'(pass_l[l]), last_pass[l]);
                chk($sformatf("sa L%0d fail_valid", l), int'(fv_l[l]), last_fv[l]);
                chk($sformatf("sa L%0d fail_vec", l), int'(fvec_l[l]), last_fvec[l]);
            end
        end
    endtask

    initial begin
        logic [3:0] m;
        int ca, cs, cr, pick;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mask  = 4'h0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run(4'h0, NONE, 0, 0);    // correct cell
        run(4'hF, NONE, 4, 0);    // XNOR cell, stray start mid-run
        both_idle();
        run(4'h6, NONE, 12, 0);   // output stuck at 0, stray start in last check of lane 0
        run(4'h0, 8, 0, 0);       // abort in lane 0 vector 10 settle
        both_idle();
        run(4'h0, NONE, 0, 0);    // clean rerun after abort
        run(4'h9, 3, 3, 0);       // abort in lane 0 check with mismatch, start ignored
        run(4'h0, NONE, 0, 20);   // reset mid-run
        both_idle();

        for (int it = 0; it < 18; it++) begin
            pick = $urandom_range(0, 3);
            case (pick)
                0: m = 4'h0;
                1: m = 4'hF;
                2: m = 4'h6;
                default: m = 4'($urandom_range(0, 15));
            endcase
            ca = ($urandom_range(0, 1) == 0) ? NONE : $urandom_range(1, 41);
            cs = $urandom_range(2, 12);
            if (cs > ca) cs = 0;
            cr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 41) : 0;
            run(m, ca, cs, cr);
            if ($urandom_range(0, 2) == 0) both_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
